// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type, default constants and parity helper
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

   localparam int CLKS_PER_BIT_9600 = 5208;
   localparam int DATA_BITS_DEF     = 8;

   // expected parity bit for a zero-extended word; odd = 1 selects odd parity
   function automatic logic parity_calc(input logic [8:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_param_sync_edge.sv
// sync_edge: SYNC_STAGES-deep input synchroniser with falling-edge detect
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic fall
);

   logic [SYNC_STAGES:0] line_q, line_d;

   // shift the raw line in; the top bit is the previous synchronised sample
   always_comb line_d = {line_q[SYNC_STAGES-1:0], din};

   // synchroniser flops reset to the idle-high line level
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) line_q <= '1;
      else line_q <= line_d;

   assign dout = line_q[SYNC_STAGES-1];
   assign fall = line_q[SYNC_STAGES] & ~line_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with ready/valid output; define UART_RX_PARITY_EN for a parity bit
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
   parameter int DATA_BITS    = DATA_BITS_DEF,
   parameter int SYNC_STAGES  = 2,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_data,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || SYNC_STAGES < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_rx_param: parameter out of range");
   end

   uart_rx_state_t       state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 data_valid_q, data_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 rx, fall, tick, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (uart_data),
      .dout (rx),
      .fall (fall)
   );

   assign tick = (cnt_q == '0);

   // frame FSM: bit timing, sampling and shift register
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
`endif
      if (state_q != IDLE) cnt_d = tick ? FULL : cnt_q - 1'b1;
      case (state_q)
         IDLE: if (fall) begin
            state_d = START;
            cnt_d   = HALF;
         end
         START: if (tick) begin
            state_d = rx ? IDLE : DATA;
            idx_d   = '0;
         end
         DATA: if (tick) begin
            shift_d = {rx, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx_q == LAST) state_d = PARITY;
`else
            if (idx_q == LAST) state_d = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick) begin
            par_bad_d = rx ^ parity_calc(9'(shift_q), PARITY_ODD != 0);
            state_d   = STOP;
         end
`endif
         STOP: if (tick) begin
            state_d  = IDLE;
            stop_ok  = rx;
            stop_bad = ~rx;
         end
         default: state_d = IDLE;
      endcase
   end

   // output handshake: consumer accept, present a new word, or flag overrun
   always_comb begin
      data_d       = data_q;
      data_valid_d = data_valid_q & ~data_ready;
      overrun_d    = 1'b0;
      frame_err_d  = stop_bad;
`ifdef UART_RX_PARITY_EN
      parity_err_d = (stop_ok | stop_bad) & par_bad_q;
`endif
      if (stop_ok) begin
         if (!data_valid_q || data_ready) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // state and output registers; reset aborts any partial frame
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign busy       = (state_q != IDLE);
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames checked against a word-queue model
module tb_uart_rx_param;

   localparam int CPB  = 16;
   localparam int PODD = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_data = 1'b1;
   logic       data_ready = 1'b1;
   logic [7:0] data;
   logic       data_valid, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int tests = 0;
   int fails = 0;
   int vcyc = 0, fe_n = 0, ov_n = 0, busy_n = 0, pe_n = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(PODD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_data (uart_data),
      .data      (data),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor samples between the negedge (input changes) and the next posedge
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (data_valid) vcyc++;
         if (frame_err) fe_n++;
         if (overrun) ov_n++;
         if (busy) busy_n++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) pe_n++;
`endif
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL word: got %0h expected none", data);
            end else check("word", data, exp_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr();
      vcyc = 0; fe_n = 0; ov_n = 0; busy_n = 0; pe_n = 0;
   endtask

   task automatic bit_out(input logic b);
      uart_data = b;
      idle(CPB);
   endtask

   function automatic logic good_par(input logic [7:0] b);
      return (^b) ^ (PODD != 0);
   endfunction

   task automatic send(input logic [7:0] b, input logic stop, input logic par);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
      bit_out(par);
`endif
      bit_out(stop);
      uart_data = 1'b1;
      idle(4);
   endtask

   initial begin
      logic [7:0] b;
      idle(3);
      check("rst_data", data, 0);
      check("rst_valid", data_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {frame_err, overrun}, 0);
      rst_n = 1'b1;
      idle(5);

      // good frame, consumer always ready
      clr();
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1, good_par(8'hA5));
      check("a5_valid_cycles", vcyc, 1);
      check("a5_frame_err", fe_n, 0);
      check("a5_overrun", ov_n, 0);
      check("a5_busy_cycles", busy_n, CPB / 2 + 9 * CPB);
      check("a5_idle", busy, 0);

      // short low glitch must be rejected at the start-bit sample
      clr();
      uart_data = 1'b0;
      idle(6);
      uart_data = 1'b1;
      idle(3 * CPB);
      check("glitch_busy_cycles", busy_n, CPB / 2);
      check("glitch_valid", vcyc, 0);
      check("glitch_flags", fe_n + ov_n, 0);

      // bad stop bit, then a good frame
      clr();
      send(8'h3C, 1'b0, good_par(8'h3C));
      idle(2 * CPB);
      check("fe_pulses", fe_n, 1);
      check("fe_valid", vcyc, 0);
      clr();
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1, good_par(8'h81));
      check("after_fe_valid", vcyc, 1);
      check("after_fe_frame_err", fe_n, 0);

      // overrun while the consumer stalls
      clr();
      data_ready = 1'b0;
      exp_q.push_back(8'h11);
      send(8'h11, 1'b1, good_par(8'h11));
      send(8'h22, 1'b1, good_par(8'h22));
      check("ovr_data_held", data, 8'h11);
      check("ovr_valid_held", data_valid, 1);
      check("ovr_pulses", ov_n, 1);
      data_ready = 1'b1;
      idle(2);
      check("ovr_valid_drop", data_valid, 0);
      check("ovr_queue_empty", exp_q.size(), 0);

      // reset mid-frame with a word pending
      data_ready = 1'b0;
      send(8'h5A, 1'b1, good_par(8'h5A));
      check("pend_data", data, 8'h5A);
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b0);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      uart_data = 1'b1;
      #1;
      check("arst_data", data, 0);
      check("arst_valid", data_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_flags", {frame_err, overrun}, 0);
      idle(3);
      rst_n = 1'b1;
      data_ready = 1'b1;
      idle(12 * CPB);
      clr();
      exp_q.push_back(8'h0F);
      send(8'h0F, 1'b1, good_par(8'h0F));
      check("post_rst_valid", vcyc, 1);
      check("post_rst_flags", fe_n + ov_n, 0);

`ifdef UART_RX_PARITY_EN
      // parity errors still deliver the word
      clr();
      exp_q.push_back(8'h07);
      send(8'h07, 1'b1, 1'b0);
      check("par_bad_pulse", pe_n, 1);
      check("par_bad_valid", vcyc, 1);
      clr();
      exp_q.push_back(8'h07);
      send(8'h07, 1'b1, 1'b1);
      check("par_good_pulse", pe_n, 0);
`endif

      // random words, back to back
      clr();
      for (int n = 0; n < 8; n++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send(b, 1'b1, good_par(b));
      end
      check("rand_valid_cycles", vcyc, 8);
      check("rand_flags", fe_n + ov_n + pe_n, 0);
      check("rand_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 9600 Hz, 8-bit UART receive front end.
- Receives asynchronous serial frames on uart_data and presents each completed word on a ready/valid output port that feeds the command decoder / DRSSTC controller register file.
- Adds mid-bit sampling, false-start rejection, stop-bit framing check, overrun detection, asynchronous reset and optional parity.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600); minimum 4.
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
SYNC_STAGES, 2, input synchroniser depth, minimum 2.
PARITY_ODD, 0, parity sense (1 = odd, 0 = even); used only when UART_RX_PARITY_EN is defined.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
uart_data  in  1  raw serial line, idle high.
data  out  DATA_BITS  received word, valid while data_valid = 1.
data_valid  out  1  word available.
data_ready  in  1  consumer accepts word when data_valid && data_ready.
busy  out  1  high while the FSM is not in IDLE.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  one-cycle pulse: completed word lost because data_valid was still pending.
parity_err  out  1  one-cycle pulse on parity mismatch; present only with UART_RX_PARITY_EN.

Behaviour:
Reset:
- While rst_n = 0: all outputs 0; state IDLE; synchroniser flops 1; counters cleared.
- Reset mid-frame aborts the frame and discards the partial word.

Input path:
- uart_data passes through SYNC_STAGES flops; falling edge detected on the synchronised signal.
- Start-edge latency: SYNC_STAGES + 1 cycles.

FSM states IDLE, START, DATA, PARITY, STOP:
- IDLE: on falling edge -> START; bit_cnt_clk loads CLKS_PER_BIT/2 - 1.
- START: counter decrements each cycle. At 0, sample the line: low -> DATA with counter CLKS_PER_BIT - 1 and bit index 0; high -> IDLE (glitch rejected, no flag).
- DATA: at counter 0, shift the sample into the shift register MSB side (LSB-first frame), reload the counter, increment the index. After DATA_BITS samples -> PARITY if the macro is defined, else STOP.
- PARITY: at counter 0, compare the sample against the computed parity and store the mismatch -> STOP.
- STOP: at counter 0, sample the line.
  - High: word complete; -> IDLE.
  - Low: frame_err pulse, word discarded; -> IDLE.
  - IDLE re-arms only on a new falling edge, so a held-low break line produces exactly one frame_err.

Output handshake (next cycle after a good stop sample):
- If data_valid = 0, or data_valid && data_ready in that cycle: data <= word, data_valid <= 1.
- If data_valid && !data_ready: old word retained, overrun pulses, new word dropped.
- data_valid falls the cycle after acceptance when no new word completes in the same cycle.
- data holds its value while data_valid = 1.
- data_ready while data_valid = 0 has no effect.

Counters and widths:
- Cycle counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1).
- No counter wraps; every counter is reloaded explicitly.

busy:
- 1 from the first START cycle through the last STOP cycle.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: PARITY state present; frame is start + DATA_BITS + parity + stop.
- parity_err pulses in the same cycle the word is presented (or would have been presented, had it been framed correctly).
- A word with bad parity is still delivered; the consumer decides.
- Undefined: no PARITY state, no parity_err port; frame is start + DATA_BITS + stop.

Decomposition:
Shared package uart_pkg:
- typedef enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP}.
- Default constants CLKS_PER_BIT_9600 and DATA_BITS_DEF.
- Helper function parity_calc(word, odd).

Sub-module sync_edge:
- SYNC_STAGES synchroniser + falling-edge detector with async active-low reset.
- Replaces the existing edge detector for this block.

Test Plan:
(All tests CLKS_PER_BIT = 16.)
- Send 0xA5, 8N1, data_ready = 1 -> data = 0xA5, data_valid high exactly 1 cycle, frame_err/overrun stay 0, busy high for ~9.5 bit times.
- 6-cycle low glitch on an idle line -> FSM back to IDLE after the START sample, no data_valid, no flags.
- Send 0x3C with stop bit forced low -> frame_err one pulse, data_valid stays 0; the next good frame 0x81 is received correctly.
- data_ready = 0; send 0x11 then 0x22 -> data = 0x11 held, overrun pulses once at the second stop. Then assert data_ready -> data_valid drops.
- Assert rst_n = 0 for 3 cycles mid-DATA of 0x55 -> all outputs 0 immediately; the following frame 0x0F is received intact.
- With UART_RX_PARITY_EN and PARITY_ODD = 0: send 0x07 with parity bit 0 -> data = 0x07, parity_err pulses. Send again with parity bit 1 -> no parity_err.
